// File: rtl/col_match_acc.sv
// col_match_acc: after a bitmap load, requests the bitmap's columns one at a time,
// XNORs each against the matching template column from a 1-cycle ROM, accumulates
// the matching-bit count into a score and flags a symbol match above a threshold.
`timescale 1ns / 1ps
module col_match_acc #(
    parameter int unsigned COLW   = 64,
    parameter int unsigned NCOLS  = 24,
    parameter int unsigned ACCW   = 11,
    parameter int unsigned THRESH = 1400,
    parameter int unsigned TMO    = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            nextcol,
    input  logic            colready,
    input  logic [COLW-1:0] columnin,
    input  logic            finalcolumn,
    output logic [4:0]      tmpl_addr,
    input  logic [COLW-1:0] tmpl_data,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] score,
    output logic            match,
    output logic            err
);

    localparam int unsigned PCW = $clog2(COLW + 1);
    localparam int unsigned TW  = $clog2(TMO + 1);

    localparam logic [4:0] LastCol = 5'(NCOLS - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StAcc  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [4:0]      col_idx_q, col_idx_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ACCW-1:0] score_q, score_d;
    logic            match_q, match_d;
    logic            err_q, err_d;

    logic [COLW-1:0] same_bits;
    logic [PCW-1:0]  pop;

    // Count of bit positions where the captured column agrees with the template.
    always_comb begin
        same_bits = ~(col_q ^ tmpl_data);
        pop       = '0;
        for (int i = 0; i < COLW; i++) begin
            pop = pop + PCW'(same_bits[i]);
        end
    end

    // Next-state logic; a start pulse overrides whatever the current state decided.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        acc_d     = acc_q;
        timer_d   = timer_q;
        col_d     = col_q;
        score_d   = score_q;
        match_d   = match_q;
        err_d     = err_q;
        case (state_q)
            StIdle: ;
            StReq: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (colready) begin
                    col_d   = columnin;
                    state_d = StAcc;
                end else if (timer_q == TW'(TMO - 1)) begin
                    // This is the TMO-th WAIT cycle with no column: give up
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StAcc: begin
                acc_d = acc_q + ACCW'(pop);
                if (col_idx_q == 5'd0) begin
                    state_d = StDone;
                end else if (finalcolumn) begin
                    // Bitmap ran out before the template did
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    col_idx_d = col_idx_q - 5'd1;
                    state_d   = StReq;
                end
            end
            StDone: begin
                score_d = acc_q;
                match_d = (acc_q >= ACCW'(THRESH)) && !err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            state_d   = StReq;
            acc_d     = '0;
            col_idx_d = LastCol;
            err_d     = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            col_idx_q <= LastCol;
            acc_q     <= '0;
            timer_q   <= '0;
            col_q     <= '0;
            score_q   <= '0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            acc_q     <= acc_d;
            timer_q   <= timer_d;
            col_q     <= col_d;
            score_q   <= score_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    // Outputs decoded from state and held registers.
    always_comb begin
        nextcol   = (state_q == StReq);
        busy      = (state_q == StReq) || (state_q == StWait) || (state_q == StAcc);
        done      = (state_q == StDone);
        tmpl_addr = col_idx_q;
        score     = score_q;
        match     = match_q;
        err       = err_q;
    end

endmodule
